// File: rtl/path_delay_meter_if.sv
// path_delay_meter_if: run control, path drive/sense and result bus of the delay meter
interface path_delay_meter_if #(
  parameter int CNT_W  = 16,
  parameter int TRIALS = 8
);
  localparam int SUM_W = CNT_W + $clog2(TRIALS);
  logic             start;
  logic             path_launch;
  logic             path_sense;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [SUM_W-1:0] delay_sum;
  logic [CNT_W-1:0] delay_min;
  logic [CNT_W-1:0] delay_max;
  modport master (
    output start, path_sense,
    input  path_launch, busy, done, timeout_err, delay_sum, delay_min, delay_max
  );
  modport slave (
    input  start, path_sense,
    output path_launch, busy, done, timeout_err, delay_sum, delay_min, delay_max
  );
endinterface

// File: rtl/path_delay_meter.sv
// path_delay_meter: launches alternating edges into a delay path and measures sum/min/max arrival in clock cycles
module path_delay_meter #(
  parameter int CNT_W     = 16,
  parameter int TRIALS    = 8,
  parameter int TIMEOUT   = 1023,
  parameter int SETTLE    = 16,
  parameter bit INVERTING = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  path_delay_meter_if.slave bus
);
  localparam int IDX_W = $clog2(TRIALS);
  localparam int SUM_W = CNT_W + IDX_W;
  localparam int ST_W  = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_LAUNCH, S_WAIT, S_ACCUM, S_DONE} state_t;
  state_t           state_q;
  logic             sync1_q, sync2_q;
  logic             launch_q, busy_q, done_q, terr_q;
  logic [IDX_W-1:0] idx_q;
  logic [ST_W-1:0]  settle_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, min_q, max_q;
  logic [SUM_W-1:0] sum_q;
  logic             hit;
  assign cnt_d = cnt_q + 1'b1;
  // arrival: synchronised sense has reached the level expected for the current launch
  assign hit = sync2_q == (launch_q ^ INVERTING);
  // two-flop synchroniser for the asynchronous path output, idling at the path's rest level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= INVERTING;
      sync2_q <= INVERTING;
    end else begin
      sync1_q <= bus.path_sense;
      sync2_q <= sync1_q;
    end
  end
  // run sequencer: settle, launch, wait for arrival, accumulate, repeat per trial
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
      idx_q    <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      min_q    <= '1;
      max_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          busy_q   <= 1'b1;
          idx_q    <= '0;
          sum_q    <= '0;
          terr_q   <= 1'b0;
          min_q    <= '1;
          max_q    <= '0;
          settle_q <= '0;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          settle_q <= settle_q + 1'b1;
          if (settle_q == ST_W'(SETTLE - 1)) state_q <= S_LAUNCH;
        end
        S_LAUNCH: begin
          launch_q <= ~launch_q;
          cnt_q    <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (hit) state_q <= S_ACCUM;
          else if (cnt_d == CNT_W'(TIMEOUT)) begin
            terr_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else cnt_q <= cnt_d;
        end
        S_ACCUM: begin
          sum_q    <= sum_q + SUM_W'(cnt_q);
          min_q    <= cnt_q < min_q ? cnt_q : min_q;
          max_q    <= cnt_q > max_q ? cnt_q : max_q;
          idx_q    <= idx_q + 1'b1;
          settle_q <= '0;
          done_q   <= idx_q == IDX_W'(TRIALS - 1);
          state_q  <= idx_q == IDX_W'(TRIALS - 1) ? S_DONE : S_SETTLE;
        end
        S_DONE: begin
          launch_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.path_launch = launch_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;
  assign bus.delay_sum   = sum_q;
  assign bus.delay_min   = min_q;
  assign bus.delay_max   = max_q;
endmodule

// File: tb/tb_path_delay_meter.sv
// tb_path_delay_meter: random and directed delay-path runs checked against a trial-level reference model
module tb_path_delay_meter;
  localparam int CW = 16, TR = 8, TO_A = 20, ST_A = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int mode = 0;
  logic dly_sense = 1'b0, pv;
  int rise_dl = 5, fall_dl = 5;
  int done_a = 0, done_b = 0;
  logic lq[$];
  always #5 clk = ~clk;
  path_delay_meter_if #(.CNT_W(CW), .TRIALS(TR)) ai();
  path_delay_meter_if #(.CNT_W(CW), .TRIALS(TR)) bi();
  path_delay_meter #(.CNT_W(CW), .TRIALS(TR), .TIMEOUT(TO_A), .SETTLE(ST_A), .INVERTING(1'b0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ai));
  path_delay_meter #(.CNT_W(CW), .TRIALS(TR), .INVERTING(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bi));
  // path models: 0 = wire loopback, 1 = transport delay per edge direction, 2 = stuck low
  assign ai.path_sense = mode == 0 ? ai.path_launch : mode == 1 ? dly_sense : 1'b0;
  assign bi.path_sense = ~bi.path_launch;
  initial forever begin
    @(ai.path_launch);
    pv = ai.path_launch;
    #(pv ? rise_dl : fall_dl);
    dly_sense = pv;
  end
  always @(ai.path_launch) lq.push_back(ai.path_launch);
  always @(negedge clk) begin
    if (ai.done) done_a++;
    if (bi.done) done_b++;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // an edge arriving (n + 1/2) periods after launch edge E0 lands between E(n) and E(n+1), giving count (n+1)+1
  function automatic int cnt_of(input int n);
    return n + 2;
  endfunction
  function automatic void ref_run(input int rn, input int fn, output int s, output int mn, output int mx);
    s = 0; mn = 'hFFFF; mx = 0;
    for (int t = 1; t <= TR; t++) begin
      int c = (t % 2 == 1) ? cnt_of(rn) : cnt_of(fn);
      s += c;
      if (c < mn) mn = c;
      if (c > mx) mx = c;
    end
  endfunction
  task automatic run_a(input string tag, input int es, input int emn, input int emx, input bit eterr, output int cyc);
    int d0;
    bit ok;
    d0 = done_a;
    lq.delete();
    @(negedge clk); ai.start = 1'b1;
    @(negedge clk); ai.start = 1'b0;
    chk({tag, " busy"}, ai.busy, 1);
    chk({tag, " terr_clr"}, ai.timeout_err, 0);
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      ok = ai.done;
    end
    chk({tag, " done_seen"}, ok, 1);
    chk({tag, " sum"}, ai.delay_sum, es);
    chk({tag, " min"}, ai.delay_min, emn);
    chk({tag, " max"}, ai.delay_max, emx);
    chk({tag, " terr"}, ai.timeout_err, eterr);
    chk({tag, " busy_at_done"}, ai.busy, 1);
    @(negedge clk); #1;
    chk({tag, " done_low"}, ai.done, 0);
    chk({tag, " busy_low"}, ai.busy, 0);
    chk({tag, " launch_end"}, ai.path_launch, 0);
    chk({tag, " done_cnt"}, done_a, d0 + 1);
  endtask
  initial begin
    int cyc, s, mn, mx, rn, fn, pat, d0;
    bit ok;
    ai.start = 1'b0;
    bi.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst launch", ai.path_launch, 0);
    chk("rst busy", ai.busy, 0);
    chk("rst done", ai.done, 0);
    chk("rst terr", ai.timeout_err, 0);
    chk("rst sum", ai.delay_sum, 0);
    chk("rst min", ai.delay_min, 'hFFFF);
    chk("rst max", ai.delay_max, 0);
    chk("rst b_min", bi.delay_min, 'hFFFF);
    rst_n = 1'b1;
    run_a("loop", 16, 2, 2, 1'b0, cyc);
    mode = 1;
    rise_dl = 45; fall_dl = 45;
    run_a("d4p5", 48, 6, 6, 1'b0, cyc);
    pat = 0;
    foreach (lq[i]) pat |= int'(lq[i]) << i;
    chk("alt count", lq.size(), TR);
    chk("alt pattern", pat, 'h55);
    rise_dl = 35; fall_dl = 15;
    run_a("asym", 32, 3, 5, 1'b0, cyc);
    repeat (4) begin
      rn = $urandom_range(0, 14);
      fn = $urandom_range(0, 14);
      rise_dl = rn * 10 + 5;
      fall_dl = fn * 10 + 5;
      ref_run(rn, fn, s, mn, mx);
      run_a($sformatf("rnd r%0d f%0d", rn, fn), s, mn, mx, 1'b0, cyc);
    end
    mode = 2;
    run_a("stuck", 0, 'hFFFF, 0, 1'b1, cyc);
    chk("stuck cycles", cyc, ST_A + 1 + TO_A);
    repeat (5) @(negedge clk);
    chk("stuck terr_hold", ai.timeout_err, 1);
    chk("stuck min_hold", ai.delay_min, 'hFFFF);
    d0 = done_b;
    @(negedge clk); bi.start = 1'b1;
    @(negedge clk); bi.start = 1'b0;
    repeat (40) @(negedge clk);
    chk("inv busy_mid", bi.busy, 1);
    bi.start = 1'b1;
    @(negedge clk); bi.start = 1'b0;
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      ok = bi.done;
    end
    chk("inv done_seen", ok, 1);
    chk("inv sum", bi.delay_sum, 16);
    chk("inv min", bi.delay_min, 2);
    chk("inv max", bi.delay_max, 2);
    chk("inv terr", bi.timeout_err, 0);
    repeat (200) @(negedge clk);
    #1;
    chk("inv done_cnt", done_b, d0 + 1);
    chk("inv busy_low", bi.busy, 0);
    chk("inv launch_end", bi.path_launch, 0);
    mode = 0;
    lq.delete();
    @(negedge clk); ai.start = 1'b1;
    @(negedge clk); ai.start = 1'b0;
    cyc = 0;
    while (lq.size() < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid trial3_reached", lq.size() >= 3, 1);
    chk("mid sum_before", ai.delay_sum, 4);
    rst_n = 1'b0;
    #1;
    chk("mid launch", ai.path_launch, 0);
    chk("mid busy", ai.busy, 0);
    chk("mid done", ai.done, 0);
    chk("mid terr", ai.timeout_err, 0);
    chk("mid sum", ai.delay_sum, 0);
    chk("mid min", ai.delay_min, 'hFFFF);
    chk("mid max", ai.delay_max, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_a("post_rst", 16, 2, 2, 1'b0, cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
